// File: rtl/dbg_guv_pkg.sv
// Shared types and constants for the dbg_guv command path.
package dbg_guv_pkg;

    localparam int unsigned CMD_WIDTH     = 32;
    localparam int unsigned BYTES_PER_CMD = 4;
    localparam int unsigned BYTE_WIDTH    = 8;
    localparam int unsigned BCNT_W        = $clog2(BYTES_PER_CMD);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_CMD - 1);

    typedef logic [CMD_WIDTH-1:0] dbg_cmd_t;

    typedef enum logic {
        ASM_IDLE    = 1'b0,
        ASM_COLLECT = 1'b1
    } asm_state_e;

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Synchronous command FIFO with a registered head word.
// Pointers carry a wrap bit so full and empty are distinguishable.
module dbg_cmd_fifo
    import dbg_guv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clear,
    input  logic     push,
    input  logic     pop,
    input  dbg_cmd_t din,
    output dbg_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    dbg_cmd_t      mem [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    dbg_cmd_t      head_d;
    logic          full_d, empty_d;
    logic          do_push, do_pop;

    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    // Next pointers, flags and head; the new head bypasses mem when it is being written now.
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        head_d = head;
        if (clear) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
        end
        empty_d = (wr_d == rd_d);
        full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
        if (!clear && !empty_d) begin
            if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) head_d = din;
            else                                           head_d = mem[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            head  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            head  <= head_d;
            full  <= full_d;
            empty <= empty_d;
        end
    end

endmodule

// File: rtl/dbg_cmd_assembler.sv
// Packs a host byte stream little-endian into 32-bit debug commands, buffers them,
// and drops a partial command whose inter-byte gap exceeds TIMEOUT_CYCLES.
module dbg_cmd_assembler
    import dbg_guv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [BYTE_WIDTH-1:0] byte_in_TDATA,
    input  logic                  byte_in_TVALID,
    output logic                  byte_in_TREADY,
    output dbg_cmd_t              cmd_out_TDATA,
    output logic                  cmd_out_TVALID,
    input  logic                  cmd_out_TREADY,
    output logic                  timeout_pulse,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    asm_state_e           state_q, state_d;
    logic [BCNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    dbg_cmd_t             shift_q, shift_d;
    logic                 rdy_en_q;
    logic                 pulse_q, pulse_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;

    logic     fifo_full, fifo_empty, fifo_push, fifo_pop;
    dbg_cmd_t fifo_head, push_word;
    logic     byte_acc, last_byte, timeout_hit;

    // rdy_en_q holds ready low through reset and releases it at the first edge after.
    assign last_byte      = (byte_cnt_q == LAST_BYTE);
    assign byte_in_TREADY = rdy_en_q & ~clear & ~(last_byte & fifo_full);
    assign byte_acc       = byte_in_TVALID & byte_in_TREADY;
    assign timeout_hit    = (state_q == ASM_COLLECT) & ~byte_acc & (idle_q == IDLE_LAST);

    assign cmd_out_TVALID = ~fifo_empty;
    assign cmd_out_TDATA  = fifo_head;
    assign fifo_pop       = cmd_out_TVALID & cmd_out_TREADY;
    assign timeout_pulse  = pulse_q;
    assign drop_count     = drop_q;

    // Assembly state register.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q    <= ASM_IDLE;
            byte_cnt_q <= '0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            idle_q     <= idle_d;
        end
    end

    // Next state: clear and timeout abandon the word; an accepted byte beats the timeout.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        idle_d     = idle_q;
        if (clear || timeout_hit) begin
            state_d    = ASM_IDLE;
            byte_cnt_d = '0;
            idle_d     = '0;
        end else if (byte_acc) begin
            state_d    = last_byte ? ASM_IDLE : ASM_COLLECT;
            byte_cnt_d = last_byte ? '0 : byte_cnt_q + BCNT_W'(1);
            idle_d     = '0;
        end else if (state_q == ASM_COLLECT) begin
            idle_d = idle_q + IDLE_W'(1);
        end else begin
            idle_d = '0;
        end
    end

    // Outputs: byte shift, FIFO push on the last byte, timeout pulse and drop count.
    always_comb begin
        shift_d   = shift_q;
        push_word = {byte_in_TDATA, shift_q[CMD_WIDTH-1:BYTE_WIDTH]};
        fifo_push = 1'b0;
        pulse_d   = timeout_hit & ~clear;
        drop_d    = drop_q;
        if (byte_acc) begin
            shift_d   = push_word;
            fifo_push = last_byte;
        end
        if (pulse_d && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            shift_q  <= '0;
            pulse_q  <= 1'b0;
            drop_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            pulse_q  <= pulse_d;
            drop_q   <= drop_d;
            rdy_en_q <= 1'b1;
        end
    end

    dbg_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (rst),
        .clear (clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_word),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_dbg_cmd_assembler.sv
// Bench for dbg_cmd_assembler: directed scenarios plus random traffic against a
// queue-based reference model of the byte packing, FIFO and timeout rules.
module tb_dbg_cmd_assembler;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;
    localparam int          SAT   = 255;

    logic        CLOCK_50 = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  byte_in_TDATA = '0;
    logic        byte_in_TVALID = 1'b0;
    logic        byte_in_TREADY;
    logic [31:0] cmd_out_TDATA;
    logic        cmd_out_TVALID;
    logic        cmd_out_TREADY = 1'b0;
    logic        timeout_pulse;
    logic [7:0]  drop_count;

    dbg_cmd_assembler #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (8)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .rst            (rst),
        .clear          (clear),
        .byte_in_TDATA  (byte_in_TDATA),
        .byte_in_TVALID (byte_in_TVALID),
        .byte_in_TREADY (byte_in_TREADY),
        .cmd_out_TDATA  (cmd_out_TDATA),
        .cmd_out_TVALID (cmd_out_TVALID),
        .cmd_out_TREADY (cmd_out_TREADY),
        .timeout_pulse  (timeout_pulse),
        .drop_count     (drop_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    // Reference model: queued command words, bytes of the current partial word,
    // consecutive idle cycles since its last byte, and the discard count.
    logic [31:0] wq[$];
    logic [7:0]  part[$];
    int          gap = 0;
    int          m_drop = 0;
    logic        m_pulse = 1'b0;
    logic        m_armed = 1'b0;
    logic        m_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("tvalid", 32'(cmd_out_TVALID), 32'(wq.size() != 0));
        if (wq.size() != 0) chk("tdata", cmd_out_TDATA, wq[0]);
        chk("pulse", 32'(timeout_pulse), 32'(m_pulse));
        chk("drop", 32'(drop_count), 32'(m_drop));
    endtask

    // One clock: drive inputs after the falling edge, step the model, check after the next fall.
    task automatic cycle(input logic v, input logic [7:0] d, input logic tr, input logic clr);
        logic rdy, pop;
        byte_in_TVALID = v;
        byte_in_TDATA  = d;
        cmd_out_TREADY = tr;
        clear          = clr;
        #1;
        rdy = m_armed && !clr && !(part.size() == 3 && wq.size() == DEPTH);
        chk("in_ready", 32'(byte_in_TREADY), 32'(rdy));
        m_acc   = v && rdy;
        pop     = tr && (wq.size() != 0);
        m_pulse = 1'b0;
        if (clr) begin
            wq.delete();
            part.delete();
            gap = 0;
        end else begin
            if (pop) void'(wq.pop_front());
            if (m_acc) begin
                part.push_back(d);
                gap = 0;
                if (part.size() == 4) begin
                    wq.push_back({part[3], part[2], part[1], part[0]});
                    part.delete();
                end
            end else if (part.size() != 0) begin
                gap++;
                if (gap == TMO) begin
                    part.delete();
                    gap     = 0;
                    m_pulse = 1'b1;
                    if (m_drop < SAT) m_drop++;
                end
            end
        end
        @(posedge CLOCK_50);
        m_armed = 1'b1;
        @(negedge CLOCK_50);
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic tr);
        int n = 0;
        do begin
            cycle(1'b1, d, tr, 1'b0);
            n++;
        end while (!m_acc && n < 64);
        chk("send_accept", 32'(m_acc), 32'd1);
    endtask

    task automatic reset_dut();
        byte_in_TVALID = 1'b0;
        cmd_out_TREADY = 1'b0;
        clear          = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_tvalid", 32'(cmd_out_TVALID), 32'd0);
        chk("rst_tdata", cmd_out_TDATA, 32'd0);
        chk("rst_ready", 32'(byte_in_TREADY), 32'd0);
        chk("rst_pulse", 32'(timeout_pulse), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        wq.delete();
        part.delete();
        gap     = 0;
        m_drop  = 0;
        m_pulse = 1'b0;
        m_armed = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        @(negedge CLOCK_50);
        reset_dut();

        // T1: one word, popped straight away
        send_byte(8'h81, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("t1_word", cmd_out_TDATA, 32'h0001_0081);
        chk("t1_valid", 32'(cmd_out_TVALID), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_one_cycle", 32'(cmd_out_TVALID), 32'd0);

        // T2: fill the FIFO, stall on the 20th byte, then drain in order
        for (int i = 0; i < 19; i++) send_byte(8'(i), 1'b0);
        byte_in_TVALID = 1'b1;
        byte_in_TDATA  = 8'd19;
        #1;
        chk("t2_stall", 32'(byte_in_TREADY), 32'd0);
        chk("t2_head", cmd_out_TDATA, 32'h0302_0100);
        cycle(1'b1, 8'd19, 1'b0, 1'b0);
        cycle(1'b1, 8'd19, 1'b1, 1'b0);
        send_byte(8'd19, 1'b1);
        repeat (8) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // T3: timeout after two bytes, then a fresh word
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            if (timeout_pulse && first == 0) first = i;
        end
        chk("t3_delay", 32'(first), 32'd16);
        chk("t3_drop", 32'(drop_count), 32'd1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        chk("t3_word", cmd_out_TDATA, 32'hDDCC_BBAA);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Byte arriving in the threshold cycle is kept
        send_byte(8'h55, 1'b1);
        repeat (TMO - 1) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        chk("thr_word", cmd_out_TDATA, 32'h8877_6655);
        chk("thr_drop", 32'(drop_count), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // T4: back-pressure holds the head stable
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            chk("t4_data", cmd_out_TDATA, 32'h0403_0201);
            chk("t4_valid", 32'(cmd_out_TVALID), 32'd1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_popped", 32'(cmd_out_TVALID), 32'd0);

        // T6: clear with two words and a partial byte pending
        for (int i = 0; i < 9; i++) send_byte(8'(8'h30 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t6_tvalid", 32'(cmd_out_TVALID), 32'd0);
        chk("t6_drop", 32'(drop_count), 32'd1);
        repeat (TMO + 4) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // T5: asynchronous reset mid-word with words queued
        for (int i = 0; i < 11; i++) send_byte(8'(8'h40 + i), 1'b0);
        reset_dut();
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b0);
        chk("t5_word", cmd_out_TDATA, 32'hA4A3_A2A1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_single", 32'(cmd_out_TVALID), 32'd0);

        // Random traffic in blocks of varying byte density and back-pressure
        for (int blk = 0; blk < 30; blk++) begin
            int unsigned pv, pr, sel;
            sel = $urandom_range(0, 2);
            pv  = (sel == 0) ? 4 : (sel == 1) ? 50 : 95;
            pr  = $urandom_range(10, 90);
            for (int c = 0; c < 100; c++) begin
                cycle($urandom_range(0, 99) < pv, 8'($urandom),
                      $urandom_range(0, 99) < pr, $urandom_range(0, 63) == 0);
            end
        end

        // Drop counter saturation
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 260; k++) begin
            send_byte(8'h5A, 1'b1);
            repeat (TMO) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("sat_drop", 32'(drop_count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
